contador_ext: RTL and testbench

Parametrised successor to the free-running LED counter for the iCE40 boards. The block combines a prescaler with a W-bit modulo counter. Features:
- enable
- up/down direction
- synchronous parallel load
- registered terminal-count pulse
- optional ping-pong (bounce) mode

It sits between the board clock and the LED pins, or feeds other blocks through `tc`.

---
 rtl/contador_pkg.sv | 25 ++
 rtl/divisor.sv | 49 ++++
 rtl/contador_ext.sv | 155 +++++++++++++++
 tb/tb_contador_ext.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// ---------------------------------------------------------------------------
// contador_pkg
// Shared definitions for the contador_ext counter block:
//   DIR_UP / DIR_DOWN : encodings of the counting / bounce direction
//   sat_load()        : clamps a parallel-load value into 0..MODULO-1
// ---------------------------------------------------------------------------
package contador_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Values at or above the modulo saturate to the top of the range so the
  // counter can never hold an out-of-range value after a load.
  function automatic logic [31:0] sat_load(input logic [31:0] value,
                                           input logic [31:0] modulo);
    logic [31:0] res;
    if (value >= modulo) begin
      res = modulo - 32'd1;
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/divisor.sv
// ---------------------------------------------------------------------------
// divisor
// N-bit free-running prescaler. Produces a one-cycle tick every 2^N enabled
// cycles; pausing ena freezes the count without losing the phase.
// Ports:
//   clk   in   system clock, rising edge
//   rstn  in   asynchronous active-low reset
//   ena   in   advance enable
//   clr   in   synchronous clear (restarts the period)
//   tick  out  high when the count is all ones and ena is high
// ---------------------------------------------------------------------------
module divisor #(
  parameter int N = 22
) (
  input  logic clk,
  input  logic rstn,
  input  logic ena,
  input  logic clr,
  output logic tick
);

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;

  // The all-ones count wraps to zero naturally on the same cycle as the tick.
  assign tick = ena & (&cnt_q);

  // Next-state selection for the prescaler count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {N{1'b0}};
    end else if (ena) begin
      cnt_d = cnt_q + {{(N-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= {N{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/contador_ext.sv
// ---------------------------------------------------------------------------
// contador_ext
// Prescaled modulo-MODULO counter with enable, up/down direction, saturating
// synchronous load, registered terminal-count pulse and optional ping-pong
// (bounce) mode.
// Build option: define CONTADOR_PINGPONG_EN to compile in the bounce logic
// and its direction register; otherwise pp is ignored.
// Ports:
//   clk   in       system clock, rising edge
//   rstn  in       asynchronous active-low reset
//   ena   in       count enable (freezes prescaler and counter when low)
//   dir   in       1 = up, 0 = down (ignored while bouncing)
//   load  in       synchronous load strobe, wins over a tick
//   din   in [W]   load value, saturated to MODULO-1
//   pp    in       ping-pong select
//   leds  out [W]  registered counter value
//   tc    out      registered one-cycle terminal-count pulse
// ---------------------------------------------------------------------------
module contador_ext
  import contador_pkg::*;
#(
  parameter int N      = 22,
  parameter int W      = 5,
  parameter int MODULO = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ena,
  input  logic         dir,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         pp,
  output logic [W-1:0] leds,
  output logic         tc
);

  localparam logic [W-1:0] MAX_V  = W'(MODULO - 1);
  localparam logic [W-1:0] ZERO_V = {W{1'b0}};
  localparam logic [W-1:0] ONE_V  = {{(W-1){1'b0}}, 1'b1};

  logic         tick_s;
  logic [W-1:0] leds_q, leds_d;
  logic         tc_q, tc_d;
  logic [W-1:0] norm_leds_s;
  logic         norm_tc_s;

  // A load also restarts the prescaler so the next step is a full period away.
  divisor #(.N(N)) u_divisor (
    .clk  (clk),
    .rstn (rstn),
    .ena  (ena),
    .clr  (load),
    .tick (tick_s)
  );

  // Plain modulo step in the direction given by dir, wrapping at the ends.
  always_comb begin
    norm_leds_s = leds_q;
    norm_tc_s   = 1'b0;
    if (dir == DIR_UP) begin
      if (leds_q == MAX_V) begin
        norm_leds_s = ZERO_V;
        norm_tc_s   = 1'b1;
      end else begin
        norm_leds_s = leds_q + ONE_V;
      end
    end else begin
      if (leds_q == ZERO_V) begin
        norm_leds_s = MAX_V;
        norm_tc_s   = 1'b1;
      end else begin
        norm_leds_s = leds_q - ONE_V;
      end
    end
  end

`ifdef CONTADOR_PINGPONG_EN
  logic bdir_q, bdir_d;

  // Next-state logic: load beats tick; pp picks bounce over plain stepping.
  // The bounce direction is kept while pp is low so re-enabling it resumes
  // in whatever direction it last had.
  always_comb begin
    leds_d = leds_q;
    tc_d   = 1'b0;
    bdir_d = bdir_q;
    if (load) begin
      leds_d = W'(sat_load(32'(din), 32'(MODULO)));
      bdir_d = DIR_UP;
    end else if (tick_s) begin
      if (pp) begin
        if ((bdir_q == DIR_UP) && (leds_q == MAX_V)) begin
          leds_d = MAX_V - ONE_V;
          bdir_d = DIR_DOWN;
          tc_d   = 1'b1;
        end else if ((bdir_q == DIR_DOWN) && (leds_q == ZERO_V)) begin
          leds_d = ONE_V;
          bdir_d = DIR_UP;
          tc_d   = 1'b1;
        end else if (bdir_q == DIR_UP) begin
          leds_d = leds_q + ONE_V;
        end else begin
          leds_d = leds_q - ONE_V;
        end
      end else begin
        leds_d = norm_leds_s;
        tc_d   = norm_tc_s;
      end
    end else begin
      leds_d = leds_q;
    end
  end

  // Bounce direction register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bdir_q <= DIR_UP;
    end else begin
      bdir_q <= bdir_d;
    end
  end
`else
  logic unused_pp_s;
  assign unused_pp_s = pp;

  // Next-state logic: load beats tick; only plain modulo stepping exists.
  always_comb begin
    leds_d = leds_q;
    tc_d   = 1'b0;
    if (load) begin
      leds_d = W'(sat_load(32'(din), 32'(MODULO)));
    end else if (tick_s) begin
      leds_d = norm_leds_s;
      tc_d   = norm_tc_s;
    end else begin
      leds_d = leds_q;
    end
  end
`endif

  // Counter value and terminal-count pulse registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      leds_q <= ZERO_V;
      tc_q   <= 1'b0;
    end else begin
      leds_q <= leds_d;
      tc_q   <= tc_d;
    end
  end

  assign leds = leds_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_contador_ext.sv
// ---------------------------------------------------------------------------
// tb_contador_ext
// Directed bench for contador_ext with N=2, W=5, MODULO=10 (tick every 4
// cycles). Expected values are computed from the counting rules below.
// ---------------------------------------------------------------------------
module tb_contador_ext;

  localparam int N      = 2;
  localparam int W      = 5;
  localparam int MODULO = 10;

  logic         clk  = 1'b0;
  logic         rstn = 1'b1;
  logic         ena  = 1'b0;
  logic         dir  = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] din  = 5'd0;
  logic         pp   = 1'b0;
  logic [W-1:0] leds;
  logic         tc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  contador_ext #(.N(N), .W(W), .MODULO(MODULO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .ena  (ena),
    .dir  (dir),
    .load (load),
    .din  (din),
    .pp   (pp),
    .leds (leds),
    .tc   (tc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across a rising edge, release on a falling edge.
  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int k;
    int e;
    #2;

    // 1: count up from reset, wrap 9 -> 0 with tc
    ena = 1'b1; dir = 1'b1; pp = 1'b0; load = 1'b0;
    do_reset();
    check("reset_leds", 32'(leds), 32'd0);
    check("reset_tc", 32'(tc), 32'd0);
    for (int c = 1; c <= 44; c++) begin
      edge1();
      check("up_leds", 32'(leds), 32'((c / 4) % 10));
      check("up_tc", 32'(tc), 32'(c == 40));
    end

    // 2: count down from reset, first step 0 -> 9 with tc
    dir = 1'b0;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      edge1();
      k = c / 4;
      check("down_leds", 32'(leds), 32'((10 - k) % 10));
      check("down_tc", 32'(tc), 32'(c == 4));
    end

    // 3: loads, saturation, load beating a wrapping tick
    ena = 1'b0; dir = 1'b1;
    do_reset();
    load = 1'b1; din = 5'd7;
    edge1();
    check("load7_leds", 32'(leds), 32'd7);
    din = 5'd20;
    edge1();
    check("load20_sat", 32'(leds), 32'd9);
    load = 1'b0; ena = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      edge1();
      check("hold9_leds", 32'(leds), 32'd9);
    end
    load = 1'b1; din = 5'd4;
    edge1();
    check("load_vs_tick_leds", 32'(leds), 32'd4);
    check("load_vs_tick_tc", 32'(tc), 32'd0);
    load = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      edge1();
      check("after_load_leds", 32'(leds), (c == 4) ? 32'd5 : 32'd4);
    end

    // 4: three-cycle enable gap delays the step by three cycles
    ena = 1'b1; dir = 1'b1;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      if (c == 3) ena = 1'b0;
      if (c == 6) ena = 1'b1;
      edge1();
      check("gap_leds", 32'(leds), (c == 7) ? 32'd1 : 32'd0);
    end

    // 5: ping-pong request (bounces only when compiled in)
    ena = 1'b1; dir = 1'b1; pp = 1'b1;
    do_reset();
    for (int c = 1; c <= 79; c++) begin
      edge1();
      k = c / 4;
`ifdef CONTADOR_PINGPONG_EN
      if (k <= 9) e = k;
      else if (k <= 18) e = 18 - k;
      else e = k - 18;
      check("pp_leds", 32'(leds), 32'(e));
      check("pp_tc", 32'(tc), 32'((c == 40) || (c == 76)));
`else
      e = k % 10;
      check("pp_off_leds", 32'(leds), 32'(e));
      check("pp_off_tc", 32'(tc), 32'((c == 40) || (c == 80)));
`endif
    end
    pp = 1'b0;

    // 6: asynchronous reset mid-count, then a full period before first step
    ena = 1'b1; dir = 1'b1;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      edge1();
    end
    check("pre_async_leds", 32'(leds), 32'd5);
    #2;
    rstn = 1'b0;
    #1;
    check("async_leds", 32'(leds), 32'd0);
    check("async_tc", 32'(tc), 32'd0);
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      edge1();
      check("post_async_leds", 32'(leds), (c == 4) ? 32'd1 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
